// File: rtl/bitwise_pkg.sv
// Shared definitions for the bitwise logic pipeline: op encodings and the
// popcount width helper.
package bitwise_pkg;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_XOR   = 3'd2;
  localparam logic [2:0] OP_NAND  = 3'd3;
  localparam logic [2:0] OP_NOR   = 3'd4;
  localparam logic [2:0] OP_XNOR  = 3'd5;
  localparam logic [2:0] OP_ANDNB = 3'd6;
  localparam logic [2:0] OP_PASSA = 3'd7;

  // Bits needed to hold a count of 0..n ones without wrapping.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bitwise_lane.sv
// One-bit op-selectable logic cell; replicated across the operand width.
module bitwise_lane
  import bitwise_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y
);

  always_comb begin
    y = 1'b0;
    case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NAND:  y = ~(a & b);
      OP_NOR:   y = ~(a | b);
      OP_XNOR:  y = ~(a ^ b);
      OP_ANDNB: y = a & ~b;
      OP_PASSA: y = a;
      default:  y = 1'b0;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_pipe.sv
// N-bit bitwise logic unit with accumulator behind a 2-stage valid/ready
// pipeline; stage 2 also registers any/all/popcount of the result.
module bitwise_logic_pipe
  import bitwise_pkg::*;
#(
  parameter int unsigned  N        = 5,
  parameter logic [N-1:0] ACC_INIT = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            a,
  input  logic [N-1:0]            b,
  input  logic [2:0]              op,
  input  logic                    acc_en,
  input  logic                    acc_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            y,
  output logic                    any,
  output logic                    all,
  output logic [cnt_width(N)-1:0] cnt
);

  localparam int CW = cnt_width(N);

  logic          s1_valid_q, s1_valid_d;
  logic [N-1:0]  s1_y_q, s1_y_d;
  logic [N-1:0]  acc_q, acc_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  y_q, y_d;
  logic          any_q, any_d;
  logic          all_q, all_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  op_a, lane_y;
  logic [CW-1:0] pop;
  logic          in_xfer, s2_load;

  assign in_ready = !rst && (!s1_valid_q || !out_valid_q || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);

  // A clear in the same cycle as an accumulate beat takes effect first.
  assign op_a = acc_en ? (acc_clr ? ACC_INIT : acc_q) : a;

  for (genvar i = 0; i < N; i++) begin : g_lane
    bitwise_lane u_lane (
      .op (op),
      .a  (op_a[i]),
      .b  (b[i]),
      .y  (lane_y[i])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + CW'(s1_y_q[i]);
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_y_d     = s1_y_q;
    acc_d      = acc_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_y_d     = lane_y;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
    if (in_xfer && acc_en) acc_d = lane_y;
    else if (acc_clr)      acc_d = ACC_INIT;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    any_d       = any_q;
    all_d       = all_q;
    cnt_d       = cnt_q;
    if (s2_load) begin
      out_valid_d = 1'b1;
      y_d         = s1_y_q;
      any_d       = |s1_y_q;
      all_d       = &s1_y_q;
      cnt_d       = pop;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_y_q      <= '0;
      acc_q       <= ACC_INIT;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      any_q       <= 1'b0;
      all_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_y_q      <= s1_y_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      any_q       <= any_d;
      all_q       <= all_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign any       = any_q;
  assign all       = all_q;
  assign cnt       = cnt_q;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Scoreboard bench for bitwise_logic_pipe: directed scenarios plus random
// traffic checked against a behavioural model of the op/accumulator rules.
module tb_bitwise_logic_pipe;

  localparam int unsigned  N        = 5;
  localparam int           CW       = $clog2(N + 1);
  localparam logic [N-1:0] ACC_INIT = '0;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [N-1:0]  a, b;
  logic [2:0]    op;
  logic          acc_en, acc_clr;
  logic          out_valid, out_ready;
  logic [N-1:0]  y;
  logic          any, all;
  logic [CW-1:0] cnt;

  int n_cmp = 0;
  int n_err = 0;
  int n_in  = 0;
  int n_out = 0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] acc_m;

  bitwise_logic_pipe #(.N(N), .ACC_INIT(ACC_INIT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .any(any), .all(all), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] ref_op(input logic [2:0] o, input logic [N-1:0] x,
                                          input logic [N-1:0] z);
    case (o)
      3'd0:    return x & z;
      3'd1:    return x | z;
      3'd2:    return x ^ z;
      3'd3:    return ~(x & z);
      3'd4:    return ~(x | z);
      3'd5:    return ~(x ^ z);
      3'd6:    return x & ~z;
      default: return x;
    endcase
  endfunction

  // Reference model: records each accepted beat and its expected result.
  always @(negedge clk) begin
    logic [N-1:0] opa, r;
    if (rst) begin
      exp_q.delete();
      acc_m = ACC_INIT;
    end else begin
      if (acc_clr) acc_m = ACC_INIT;
      if (in_valid && in_ready) begin
        opa = acc_en ? acc_m : a;
        r   = ref_op(op, opa, b);
        if (acc_en) acc_m = r;
        exp_q.push_back(r);
        n_in++;
      end
    end
  end

  // Monitor: pops expected results on out-transfers and checks stall stability.
  logic          stall_prev = 1'b0;
  logic [N-1:0]  y_prev;
  logic          any_prev, all_prev;
  logic [CW-1:0] cnt_prev;
  always @(negedge clk) begin
    logic [N-1:0] e;
    if (!rst) begin
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_y",     32'(y),         32'(y_prev));
        chk("stall_any",   32'(any),       32'(any_prev));
        chk("stall_all",   32'(all),       32'(all_prev));
        chk("stall_cnt",   32'(cnt),       32'(cnt_prev));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(y), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("y",   32'(y),   32'(e));
          chk("any", 32'(any), 32'(|e));
          chk("all", 32'(all), 32'(&e));
          chk("cnt", 32'(cnt), 32'($countones(e)));
        end
      end
    end
    stall_prev = !rst && out_valid && !out_ready;
    y_prev     = y;
    any_prev   = any;
    all_prev   = all;
    cnt_prev   = cnt;
  end

  task automatic idle_inputs();
    in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
  endtask

  // Called just after a posedge; returns just after the posedge that accepted the beat.
  task automatic send(input logic [2:0] o, input logic [N-1:0] aa, input logic [N-1:0] bb,
                      input logic en, input logic clr);
    int guard = 0;
    in_valid = 1'b1; op = o; a = aa; b = bb; acc_en = en; acc_clr = clr;
    do begin
      @(negedge clk);
      guard++;
    end while (!in_ready && guard < 200);
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic drain(input int cycles);
    idle_inputs();
    out_ready = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst = 1'b1; idle_inputs(); a = '0; b = '0; op = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y",         32'(y),         32'd0);
    chk("rst_cnt",       32'(cnt),       32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Latency and single-cycle valid
    send(3'd0, 5'b10010, 5'b00111, 1'b0, 1'b0);
    @(negedge clk); chk("lat_c1_valid", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_c2_valid", 32'(out_valid), 32'd1);
    chk("lat_y",   32'(y),   32'b00010);
    chk("lat_cnt", 32'(cnt), 32'd1);
    @(negedge clk); chk("lat_c3_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Back-to-back OR, XOR, NOR
    send(3'd1, 5'b01110, 5'b11111, 1'b0, 1'b0);
    send(3'd2, 5'b01110, 5'b11111, 1'b0, 1'b0);
    send(3'd4, 5'b01110, 5'b11111, 1'b0, 1'b0);
    drain(5);

    // Backpressure: two beats fill the pipe, third must wait
    out_ready = 1'b0;
    send(3'd0, 5'b11111, 5'b10101, 1'b0, 1'b0);
    send(3'd1, 5'b00000, 5'b01010, 1'b0, 1'b0);
    in_valid = 1'b1; op = 3'd2; a = 5'b11100; b = 5'b00111;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_y_first",  32'(y),        32'b10101);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'd2, 5'b11100, 5'b00111, 1'b0, 1'b0);
    drain(5);

    // Accumulate chain, then clear coincident with an accumulate beat
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    send(3'd1, 5'b11111, 5'b00001, 1'b1, 1'b0);
    send(3'd1, 5'b11111, 5'b00100, 1'b1, 1'b0);
    send(3'd1, 5'b11111, 5'b10000, 1'b1, 1'b0);
    send(3'd1, 5'b11111, 5'b00010, 1'b1, 1'b1);
    drain(5);

    // Reset with both stages full
    out_ready = 1'b0;
    send(3'd1, 5'b00011, 5'b00100, 1'b0, 1'b0);
    send(3'd7, 5'b11011, 5'b00000, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk); chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_y",         32'(y),         32'd0);
    chk("mid_rst_cnt",       32'(cnt),       32'd0);
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk); chk("mid_rst_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send(3'd0, 5'b10110, 5'b11000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("fresh_valid", 32'(out_valid), 32'd1);
    chk("fresh_y",     32'(y),         32'b10000);
    chk("fresh_cnt",   32'(cnt),       32'd1);
    drain(4);

    // Random traffic
    guard = 0;
    begin
      int base = n_in;
      while (n_in - base < 1000 && guard < 20000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        op        = 3'($urandom_range(0, 7));
        a         = N'($urandom);
        b         = N'($urandom);
        acc_en    = ($urandom_range(0, 2) == 0);
        acc_clr   = ($urandom_range(0, 15) == 0);
        out_ready = ($urandom_range(0, 2) != 0);
        @(posedge clk); #1;
        guard++;
      end
      if (n_in - base < 1000) chk("random_beats", 32'(n_in - base), 32'd1000);
    end
    drain(6);
    chk("in_out_balance", 32'(n_out), 32'(n_in - 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
